// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (G0=111, G1=110).
// Four-state ACS with register-exchange survivors and a fixed decode depth.
module viterbi_decoder #(
  parameter int unsigned TB_DEPTH = 15,
  parameter int unsigned METRIC_W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in,
  output logic out_valid,
  output logic out
);

  localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] PM_MAX  = '1;
  localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(4);

  logic                r_phase;
  logic                r_g0;
  logic [CNT_W-1:0]    r_cnt;
  logic [METRIC_W-1:0] r_pm   [4];
  logic [TB_DEPTH-1:0] r_path [4];
  logic                r_out;
  logic                r_out_valid;

  logic [METRIC_W-1:0] w_pm_raw   [4];
  logic [METRIC_W-1:0] w_pm_new   [4];
  logic [TB_DEPTH-1:0] w_path_new [4];
  logic [METRIC_W-1:0] w_min;
  logic [1:0]          w_best;
  logic                w_last_pair;

  // Next state n = {u,a}; predecessors are {a,0} and {a,1}.
  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam int unsigned U  = n / 2;
    localparam int unsigned A  = n % 2;
    localparam logic        G1 = logic'(U ^ A);
    localparam logic        UB = logic'(U);

    logic [1:0]          w_bm0, w_bm1;
    logic [METRIC_W+1:0] w_sum0, w_sum1;
    logic [METRIC_W-1:0] w_c0, w_c1;
    logic                w_sel;
    logic [TB_DEPTH-1:0] w_prev;

    // For b=0 the expected G0 equals G1; for b=1 it is inverted.
    assign w_bm0  = {1'b0, r_g0 != G1} + {1'b0, in != G1};
    assign w_bm1  = {1'b0, r_g0 == G1} + {1'b0, in != G1};
    assign w_sum0 = {2'b00, r_pm[2*A]}     + {{METRIC_W{1'b0}}, w_bm0};
    assign w_sum1 = {2'b00, r_pm[2*A + 1]} + {{METRIC_W{1'b0}}, w_bm1};
    assign w_c0   = (w_sum0 > {2'b00, PM_MAX}) ? PM_MAX : w_sum0[METRIC_W-1:0];
    assign w_c1   = (w_sum1 > {2'b00, PM_MAX}) ? PM_MAX : w_sum1[METRIC_W-1:0];
    assign w_sel  = w_c1 < w_c0;
    assign w_prev = w_sel ? r_path[2*A + 1] : r_path[2*A];

    assign w_pm_raw[n]   = w_sel ? w_c1 : w_c0;
    assign w_pm_new[n]   = w_pm_raw[n] - w_min;
    assign w_path_new[n] = (w_prev << 1) | TB_DEPTH'(UB);
  end

  always_comb begin
    w_min  = w_pm_raw[0];
    w_best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_pm_raw[i] < w_min) begin
        w_min  = w_pm_raw[i];
        w_best = 2'(i);
      end
    end
  end

  assign w_last_pair = ({1'b0, r_cnt} + 1'b1) >= (CNT_W + 1)'(TB_DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase     <= 1'b0;
      r_g0        <= 1'b0;
      r_cnt       <= '0;
      r_pm[0]     <= '0;
      r_pm[1]     <= PM_INIT;
      r_pm[2]     <= PM_INIT;
      r_pm[3]     <= PM_INIT;
      for (int i = 0; i < 4; i++) r_path[i] <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        if (!r_phase) begin
          r_g0    <= in;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          for (int i = 0; i < 4; i++) begin
            r_pm[i]   <= w_pm_new[i];
            r_path[i] <= w_path_new[i];
          end
          if (r_cnt != CNT_W'(TB_DEPTH)) r_cnt <= r_cnt + 1'b1;
          r_out       <= w_path_new[w_best][TB_DEPTH-1];
          r_out_valid <= w_last_pair;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: directed coded streams with hand-derived
// expected bits; a monitor pops expectations whenever out_valid is seen.
module tb_viterbi_decoder;

  localparam int D = 15;
  localparam int NP = 28;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in = 1'b0;
  logic out_valid;
  logic out;

  always #5 clock = ~clock;

  viterbi_decoder #(.TB_DEPTH(D), .METRIC_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in(in),
    .out_valid(out_valid),
    .out(out)
  );

  typedef struct {
    logic val;
    int   pair;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   pairs_sent = 0;
  bit   sb_en = 1'b1;

  // Coded pairs {G0,G1} for u = 1,0,1,1,0,0,1,0 then zeros, encoder from state 00.
  logic [1:0] coded [NP] = '{0: 2'b11, 1: 2'b11, 2: 2'b01, 3: 2'b00, 4: 2'b01,
                             5: 2'b10, 6: 2'b11, 7: 2'b11, 8: 2'b10, default: 2'b00};
  logic       data_u [NP] = '{0: 1'b1, 2: 1'b1, 3: 1'b1, 6: 1'b1, default: 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1 && sb_en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: out=%b with no expected entry at %0t", out, $time);
      end else begin
        e = sb_q.pop_front();
        check("out_bit", 32'(out), 32'(e.val));
        check("out_pair", pairs_sent, e.pair);
      end
    end
  end

  task automatic send_sym(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b1;
    in = b;
  endtask

  task automatic send_pair(input logic [1:0] p, input int gap0, input int gap1,
                           input bit push, input logic ev);
    exp_t e;
    send_sym(p[1], gap0);
    send_sym(p[0], gap1);
    pairs_sent++;
    if (push) begin
      e.val = ev;
      e.pair = pairs_sent;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    pairs_sent = 0;
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_reset_state();
    check("rst_pm0", 32'(dut.r_pm[0]), 0);
    check("rst_pm1", 32'(dut.r_pm[1]), 4);
    check("rst_pm2", 32'(dut.r_pm[2]), 4);
    check("rst_pm3", 32'(dut.r_pm[3]), 4);
    check("rst_phase", 32'(dut.r_phase), 0);
  endtask

  task automatic run_stream(input int flip);
    logic [1:0] p;
    logic       ev;
    for (int j = 0; j < NP; j++) begin
      p = coded[j];
      if (j == flip) p[1] = ~p[1];
      ev = 1'b0;
      if (j >= D - 1) ev = data_u[j-D+1];
      send_pair(p, 0, 0, j >= D - 1, ev);
    end
    idle();
    check("stream_drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int mn;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check_reset_state();
    check("rst_out", 32'(out), 0);
    check("rst_out_valid", 32'(out_valid), 0);

    // Error-free decode
    run_stream(-1);

    // Single channel error on G0 of pair 3
    do_reset();
    run_stream(3);

    // Asynchronous reset while out_valid and out are both high
    do_reset();
    for (int j = 0; j < D; j++) send_pair(coded[j], 0, 0, j == D - 1, 1'b1);
    @(posedge clock);
    #2;
    check("pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    pairs_sent = 0;
    @(negedge clock);
    reset = 1'b1;
    check_reset_state();

    // Gapped all-zero stream
    for (int j = 0; j < 30; j++)
      send_pair(2'b00, $urandom_range(0, 5), $urandom_range(0, 5), j >= D - 1, 1'b0);
    idle();
    repeat (3) @(negedge clock);
    check("gap_drain", sb_q.size(), 0);

    // Lone G0 followed by reset must not pair with the next symbol
    do_reset();
    send_sym(1'b1, 0);
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_reset_state();
    run_stream(-1);

    // Random symbols: normalized metrics and known output
    sb_en = 1'b0;
    do_reset();
    for (int j = 0; j < 250; j++) begin
      send_sym(1'($urandom_range(0, 1)), 0);
      send_sym(1'($urandom_range(0, 1)), 0);
      @(posedge clock);
      #1;
      mn = 32'(dut.r_pm[0]);
      for (int i = 1; i < 4; i++) if (32'(dut.r_pm[i]) < mn) mn = 32'(dut.r_pm[i]);
      check("pm_min_zero", mn, 0);
      check("out_known", 32'($isunknown(out)), 0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by the team's encoder block.
- Generators: G0 = u^a^b (111), G1 = u^a (110). u is the current input; a and b are the previous two inputs.
- Takes the serial coded stream, G0 then G1 per input bit, and recovers the original bit stream.
- Uses a 4-state add-compare-select (ACS) stage with register-exchange survivor storage and a fixed decode depth.
- Sits at the receive end of the PRML channel model, directly downstream of the encoder/channel.

Parameters:
- TB_DEPTH, 15: survivor path length in decoded bits; decode latency in pairs is TB_DEPTH-1. Legal range 4..32.
- METRIC_W, 4: path-metric width in bits. Metrics saturate at 2^METRIC_W-1.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies `in` for one symbol on this clock edge.
- in  input  1  coded symbol bit; pairs arrive G0 first, then G1.
- out_valid  output  1  one-cycle pulse, decoded bit valid.
- out  output  1  decoded data bit.

Behaviour:
- Reset (reset=0, async) clears the following:
  - phase=0, pair counter=0, g0 latch=0.
  - All survivor paths=0.
  - Metrics PM[00]=0, PM[01]=PM[10]=PM[11]=4, since the encoder starts in state 00.
  - out=0, out_valid=0.
- Symbol pairing:
  - in_valid=0: no state change except out_valid, which drops to 0.
  - in_valid=1 with phase=0: latch `in` as r0, set phase=1.
  - in_valid=1 with phase=1: `in` is r1, set phase=0, perform one trellis step on the same edge.
  - Back-to-back in_valid and arbitrary gaps are both legal.
- State encoding: state s = {a,b}, a = most recent input. Next state n = {u,a}. The predecessors of n are {a,0} and {a,1}.
- Branch metric: BM = (r0 != u^a^b) + (r1 != u^a), range 0..2.
- ACS, for each n:
  - cand_b = PM[{a,b}] + BM_b.
  - Select the smaller; on a tie select b=0.
  - Sums saturate at 2^METRIC_W-1.
- Normalization: subtract min over n of the new metrics from all four before storing. After every step min PM = 0.
- Survivor update: path[n] = {path[sel][TB_DEPTH-2:0], u}. Bit 0 is the newest.
- Output selection:
  - best = state with the minimum new metric; ties go to the lowest index.
  - On the trellis-step edge, out <= path_new[best][TB_DEPTH-1].
- Pair counter saturates at TB_DEPTH.
- out_valid <= 1 on a trellis-step edge when the pair count including this step is >= TB_DEPTH, else 0. It is high exactly one cycle per qualifying pair.
- out holds its value between pulses.
- Latency: the decoded bit for input pair k, 0-based, is emitted on the edge accepting the G1 symbol of pair k+TB_DEPTH-1.
- Reset mid-pair discards the half-received pair. Reset mid-stream discards all survivors; decoding restarts assuming encoder state 00.
- No flush/tail handling: the final TB_DEPTH-1 bits are emitted only if the stream continues (e.g. zero tail).

Test Plan:
- Reset: assert reset=0 mid-operation.
  - Required: out=0, out_valid=0 immediately, asynchronously.
  - Required after release: internal PM = {0,4,4,4}, phase=0.
- Error-free decode, TB_DEPTH=15:
  - Stimulus: u = 1,0,1,1,0,0,1,0 then 20 zeros. Coded pairs begin 11,11,01,...
  - Required: first out_valid at the 15th pair's G1 edge, out=1.
  - Required: subsequent outputs reproduce u in order, with exactly one out_valid per pair.
- Single error correction:
  - Stimulus: same stream with the G0 bit of pair 3 flipped.
  - Required: decoded sequence identical to the error-free case, same timing.
- Gapped input:
  - Stimulus: all-zero data, coded stream of 00 pairs, in_valid deasserted for 0-5 random cycles between symbols, including between G0 and G1 of a pair.
  - Required: out always 0, out_valid count = pairs - 14.
- Reset after a lone G0:
  - Stimulus: send one G0 symbol, pulse reset, then resend the full error-free stream.
  - Required: output identical to the error-free test; the stale symbol is not paired.
- Metric bounds:
  - Stimulus: 500 random symbol bits with continuous in_valid.
  - Required assertion: all PM <= 15 and min PM = 0 after every trellis step.
  - Required: no X on out.
